// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO between a slower CPU clock domain and a UART
// transmitter, with an autonomous drain state machine.
//
// The CPU clock is never used as a clock here. It arrives already sampled
// twice into clk as data_clk; the pattern 2'b01 marks one CPU rising edge,
// so at most one byte is accepted per CPU edge however long wr_en stays high.
//
// Drain sequence: IDLE -> LOAD (latch head byte, pop) -> REQ (raise send_req)
// -> WAIT_ACK (hold send_req until the transmitter reports busy) ->
// WAIT_DONE (wait for the transmitter to go idle) -> IDLE.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   data_clk   in   [1:0] two-stage sample of the CPU clock
//   wr_en      in   CPU write request
//   wr_byte    in   [7:0] byte to enqueue
//   tx_busy    in   transmitter busy
//   send_req   out  transmit request (registered)
//   tx_byte    out  [7:0] byte presented to the transmitter (registered)
//   fifo_full  out  occupancy == DEPTH (registered)
//   fifo_empty out  occupancy == 0 (registered)
//   count      out  [log2(DEPTH):0] occupancy (registered)
//   overflow   out  sticky dropped-write flag, only with UART_TX_FIFO_OVF_FLAG_EN
//
// Optional build macro: UART_TX_FIFO_OVF_FLAG_EN adds the overflow output.
// DEPTH must be a power of two between 4 and 64.

module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             data_clk,
    input  logic                   wr_en,
    input  logic [7:0]             wr_byte,
    input  logic                   tx_busy,
    output logic                   send_req,
    output logic [7:0]             tx_byte,
    output logic                   fifo_full,
    output logic                   fifo_empty,
`ifdef UART_TX_FIFO_OVF_FLAG_EN
    output logic                   overflow,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ZERO   = {(AW + 1){1'b0}};
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        REQ       = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_next_s;
    logic          cpu_edge_s;
    logic          wr_accept_s;
    logic          pop_s;
    logic          send_req_next_s;

    // A write is taken only on a CPU edge and only if the registered full flag
    // is low, so a pop in the same cycle never makes room for a full-FIFO write.
    assign cpu_edge_s  = (data_clk == 2'b01);
    assign wr_accept_s = cpu_edge_s & wr_en & ~fifo_full;
    // LOAD is only entered with a non-empty FIFO and nothing else pops, so
    // the pop can never underflow.
    assign pop_s       = (state_r == LOAD);

    // Next occupancy: a simultaneous write and pop cancel out.
    always_comb begin
        count_next_s = count;
        if (wr_accept_s && !pop_s) begin
            count_next_s = count + CNT_ONE;
        end else if (!wr_accept_s && pop_s) begin
            count_next_s = count - CNT_ONE;
        end else begin
            count_next_s = count;
        end
    end

    // Drain FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD:     state_next_s = REQ;
            REQ:      state_next_s = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_next_s = WAIT_DONE;
                end else begin
                    state_next_s = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default:  state_next_s = IDLE;
        endcase
    end

    // send_req is registered from the next state so it is high exactly
    // while the FSM sits in REQ or WAIT_ACK.
    assign send_req_next_s = (state_next_s == REQ) || (state_next_s == WAIT_ACK);

    // Storage array; no reset needed, reads only reach written entries.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= wr_byte;
        end
    end

    // Pointers, occupancy, flags, FSM state and transmitter-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count      <= CNT_ZERO;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            state_r    <= IDLE;
            send_req   <= 1'b0;
            tx_byte    <= 8'h00;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                tx_byte  <= mem_r[rd_ptr_r];
            end
            count      <= count_next_s;
            fifo_full  <= (count_next_s == FULL_COUNT);
            fifo_empty <= (count_next_s == CNT_ZERO);
            state_r    <= state_next_s;
            send_req   <= send_req_next_s;
        end
    end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
    // Sticky flag for any CPU write dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cpu_edge_s && wr_en && fifo_full) begin
            overflow <= 1'b1;
        end else begin
            overflow <= overflow;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a vector table for the fill/gating
// behaviour, a byte scoreboard fed on every accepted write and emptied by a
// small transmitter model, and hand-written sequences for latency, same-cycle
// write/pop with pointer wrap, and reset during a transfer.

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    data_clk;
    logic          wr_en;
    logic [7:0]    wr_byte;
    logic          tx_busy;
    logic          send_req;
    logic [7:0]    tx_byte;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] count;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
    logic          overflow;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_clk   (data_clk),
        .wr_en      (wr_en),
        .wr_byte    (wr_byte),
        .tx_busy    (tx_busy),
        .send_req   (send_req),
        .tx_byte    (tx_byte),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
`ifdef UART_TX_FIFO_OVF_FLAG_EN
        .overflow   (overflow),
`endif
        .count      (count)
    );

    typedef struct {
        logic [1:0]    dclk;
        logic          wen;
        logic [7:0]    data;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       xmtr_en;
    logic       busy_hold;
    logic       model_busy;
    logic       prev_req;
    logic       hold_ok;
    int         busy_cnt;
    int         pulses;
    int         bytes_tx;
    int         n;
    logic [1:0] cpu_seq [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the byte on tx_byte with the oldest expected byte.
    task automatic check_tx();
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got %02h required no byte", tx_byte);
        end else begin
            exp = sb_q.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(exp));
        end
        bytes_tx++;
    endtask

    // Transmitter model: accepts a request, stays busy for three cycles.
    task automatic xmtr_step();
        if (send_req && !prev_req) pulses++;
        prev_req = send_req;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end else if (send_req && !model_busy) begin
            check_tx();
            model_busy = 1'b1;
            busy_cnt   = 3;
        end
    endtask

    // One clock: drive tx_busy, pass the rising edge, sample on the falling edge.
    task automatic tick();
        tx_busy = xmtr_en ? model_busy : busy_hold;
        @(posedge clk);
        @(negedge clk);
        if (xmtr_en) xmtr_step();
    endtask

    // Single-cycle CPU write.
    task automatic wr(input logic [7:0] b);
        data_clk = 2'b01;
        wr_en    = 1'b1;
        wr_byte  = b;
        if (sb_q.size() < DEPTH) sb_q.push_back(b);
        tick();
        data_clk = 2'b11;
        wr_en    = 1'b0;
    endtask

    // Let the transmitter model empty the FIFO, bounded.
    task automatic drain(input int bound);
        int k;
        k = 0;
        xmtr_en  = 1'b1;
        prev_req = send_req;
        while ((sb_q.size() != 0 || model_busy) && k < bound) begin
            tick();
            k++;
        end
        check("drain_left", 32'(sb_q.size()), 32'd0);
        tick();
        tick();
        xmtr_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; data_clk = 2'b00; wr_en = 1'b0; wr_byte = 8'h00; tx_busy = 1'b0;
        xmtr_en = 1'b0; busy_hold = 1'b0; model_busy = 1'b0; prev_req = 1'b0;
        busy_cnt = 0; pulses = 0; bytes_tx = 0;

        // Vector table: gating of writes, fill to full, dropped 17th write.
        vecs.push_back('{2'b00, 1'b1, 8'hAA, CW'(0), 1'b0, 1'b1});
        vecs.push_back('{2'b10, 1'b1, 8'hAA, CW'(0), 1'b0, 1'b1});
        vecs.push_back('{2'b11, 1'b1, 8'hAA, CW'(0), 1'b0, 1'b1});
        vecs.push_back('{2'b01, 1'b0, 8'hAA, CW'(0), 1'b0, 1'b1});
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{2'b01, 1'b1, 8'(i), CW'(i + 1), (i == 15), 1'b0});
            vecs.push_back('{2'b11, 1'b1, 8'(i), CW'(i + 1), (i == 15), 1'b0});
        end
        vecs.push_back('{2'b01, 1'b1, 8'hFF, CW'(16), 1'b1, 1'b0});
        vecs.push_back('{2'b11, 1'b0, 8'h00, CW'(16), 1'b1, 1'b0});

        // Reset state.
        tick(); tick();
        check("rst_send_req", 32'(send_req), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
`ifdef UART_TX_FIFO_OVF_FLAG_EN
        check("rst_overflow", 32'(overflow), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Single byte with an idle transmitter.
        wr(8'h41);
        check("wr_count", 32'(count), 32'd1);
        check("wr_not_empty", 32'(fifo_empty), 32'd0);
        n = 0;
        while (!send_req && n < 8) begin tick(); n++; end
        check("load_latency_ok", 32'(n >= 2 && n <= 3), 32'd1);
        check("pop_empty", 32'(fifo_empty), 32'd1);
        check_tx();
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!send_req) hold_ok = 1'b0;
        end
        check("req_hold", 32'(hold_ok), 32'd1);
        busy_hold = 1'b1;
        tick();
        check("req_drop", 32'(send_req), 32'd0);
        check("tx_byte_stable", 32'(tx_byte), 32'h41);
        busy_hold = 1'b0;
        tick(); tick();

        // Table-driven fill with the transmitter held busy.
        busy_hold = 1'b1;
        foreach (vecs[k]) begin
            data_clk = vecs[k].dclk;
            wr_en    = vecs[k].wen;
            wr_byte  = vecs[k].data;
            if (vecs[k].dclk == 2'b01 && vecs[k].wen && sb_q.size() < DEPTH)
                sb_q.push_back(vecs[k].data);
            tick();
            check("vec_count", 32'(count), 32'(vecs[k].cnt));
            check("vec_full", 32'(fifo_full), 32'(vecs[k].full));
            check("vec_empty", 32'(fifo_empty), 32'(vecs[k].empty));
        end
`ifdef UART_TX_FIFO_OVF_FLAG_EN
        check("overflow_set", 32'(overflow), 32'd1);
`endif

        // Drain all 16 in order, one request pulse per byte.
        pulses = 0; bytes_tx = 0;
        drain(400);
        check("drain_bytes", 32'(bytes_tx), 32'd16);
        check("drain_pulses", 32'(pulses), 32'd16);
        check("drain_empty", 32'(fifo_empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // wr_en held for 5 cycles across one CPU edge -> one byte.
        busy_hold = 1'b1;
        cpu_seq = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10};
        for (int i = 0; i < 5; i++) begin
            data_clk = cpu_seq[i];
            wr_en    = 1'b1;
            wr_byte  = 8'h5A;
            if (cpu_seq[i] == 2'b01) sb_q.push_back(8'h5A);
            tick();
        end
        wr_en = 1'b0; data_clk = 2'b00;
        tick();
        check("one_per_edge", 32'(count), 32'd1);
        drain(100);

        // Same-cycle write and LOAD at count 3, wr_ptr wrapping 15 -> 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
`ifdef UART_TX_FIFO_OVF_FLAG_EN
        check("overflow_cleared", 32'(overflow), 32'd0);
`endif
        busy_hold = 1'b1;
        for (int i = 0; i < 12; i++) wr(8'(8'h80 + i));
        drain(300);
        busy_hold = 1'b1;
        wr(8'h30); wr(8'h31); wr(8'h32);
        check("pre_load_count", 32'(count), 32'd3);
        busy_hold = 1'b0;
        tick();
        data_clk = 2'b01; wr_en = 1'b1; wr_byte = 8'h33;
        sb_q.push_back(8'h33);
        tick();
        data_clk = 2'b11; wr_en = 1'b0;
        check("same_cycle_count", 32'(count), 32'd3);
        wr(8'h34);
        check("wrap_count", 32'(count), 32'd4);
        drain(200);

        // Reset while in WAIT_ACK with four bytes still queued.
        busy_hold = 1'b1;
        for (int i = 0; i < 5; i++) wr(8'(8'h50 + i));
        busy_hold = 1'b0;
        tick(); tick(); tick();
        check("wack_count", 32'(count), 32'd4);
        check("wack_req", 32'(send_req), 32'd1);
        check("wack_byte", 32'(tx_byte), 32'h50);
        reset = 1'b1;
        sb_q.delete();
        tick();
        reset = 1'b0;
        check("abort_req", 32'(send_req), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_empty", 32'(fifo_empty), 32'd1);
        check("abort_tx_byte", 32'(tx_byte), 32'h00);
        tick();
        check("abort_idle", 32'(send_req), 32'd0);
        wr(8'h77);
        n = 0;
        while (!send_req && n < 8) begin tick(); n++; end
        check("post_abort_latency_ok", 32'(n >= 2 && n <= 3), 32'd1);
        check_tx();
        busy_hold = 1'b1;
        tick();
        busy_hold = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of two, 4..64.
REQ-002 SHALL have port clk  input  1  100 MHz system clock; only clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port data_clk  input  2  two-stage sample of the CPU clock; 2'b01 marks a CPU rising edge.
REQ-005 SHALL have port wr_en  input  1  CPU write request, registered in the CPU clock domain.
REQ-006 SHALL have port wr_byte  input  8  byte to enqueue.
REQ-007 SHALL have port tx_busy  input  1  busy output from the UART transmitter.
REQ-008 SHALL have port send_req  output  1  transmit request to the UART transmitter.
REQ-009 SHALL have port tx_byte  output  8  byte presented to the transmitter.
REQ-010 SHALL have port fifo_full  output  1  high when count == DEPTH.
REQ-011 SHALL have port fifo_empty  output  1  high when count == 0.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL accept a write only in a cycle where data_clk == 2'b01, wr_en == 1 and fifo_full == 0; at most one write per CPU edge.
REQ-014 SHALL store accepted bytes at wr_ptr and increment wr_ptr modulo DEPTH; rd_ptr wraps identically.
REQ-015 SHALL silently drop a write while full, leaving pointers, count and stored data unchanged.
REQ-016 SHALL update count, fifo_full and fifo_empty one cycle after the write or pop that changes them, registered and never combinational.
REQ-017 SHALL run a drain FSM with states IDLE, LOAD, REQ, WAIT_ACK and WAIT_DONE.
REQ-018 IDLE: when fifo_empty == 0 and tx_busy == 0, go to LOAD.
REQ-019 LOAD: latch mem[rd_ptr] into tx_byte, pop the entry (rd_ptr+1, count-1), and go to REQ.
REQ-020 REQ: drive send_req = 1 and go to WAIT_ACK.
REQ-021 WAIT_ACK: hold send_req = 1 until tx_busy == 1, then deassert send_req and go to WAIT_DONE.
REQ-022 WAIT_DONE: when tx_busy == 0, go to IDLE; back-to-back bytes therefore need no CPU intervention.
REQ-023 SHALL hold tx_byte stable from LOAD until leaving WAIT_DONE.
REQ-024 SHALL, on a write and a LOAD pop in the same cycle, perform both and leave count unchanged; a write to a full FIFO is still dropped even if a pop occurs that cycle.
REQ-025 SHALL make a byte written into an empty FIFO reach LOAD no earlier than 2 cycles after the write cycle.

Reset
REQ-026 On reset: wr_ptr = 0, rd_ptr = 0, count = 0, fifo_empty = 1, fifo_full = 0, send_req = 0, tx_byte = 8'h00, FSM = IDLE.
REQ-027 Reset asserted mid-transfer SHALL abort the drain at once; the byte in flight and all queued bytes are discarded.
REQ-028 Storage array contents SHALL need no reset.

Configuration
REQ-029 Macro UART_TX_FIFO_OVF_FLAG_EN defined: add output overflow (1 bit), set sticky on any dropped write (REQ-015) and cleared only by reset.
REQ-030 Macro UART_TX_FIFO_OVF_FLAG_EN undefined: the overflow port and its logic SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset, then write 8'h41 on one data_clk==01 edge with tx_busy low -> LOAD within 2-3 cycles, tx_byte=8'h41, send_req=1 until tx_busy rises, fifo_empty=1 afterwards.
REQ-032 Write 16 bytes 8'h00..8'h0F with tx_busy held high, then a 17th write 8'hFF -> fifo_full=1, count=16, 8'hFF dropped, overflow=1 when macro defined.
REQ-033 Release tx_busy in REQ-032 and model the transmitter -> bytes 8'h00..8'h0F leave in order, with exactly one send_req pulse per byte.
REQ-034 Hold wr_en=1 for 5 cycles within one CPU clock period -> exactly one byte enqueued, count=1.
REQ-035 Write on the same cycle as a LOAD with count=3 -> count remains 3 and order is preserved across the wr_ptr wrap at index 15->0.
REQ-036 Assert reset during WAIT_ACK with count=4 -> next cycle send_req=0, count=0, fifo_empty=1, FSM=IDLE.
